venom_ammo_ctrl: RTL and testbench
==================================

# venom_ammo_ctrl

Parametrised shot/ammo controller for the player's venom weapon. It sits between the USB keyboard keycode bus and the projectile spawner and sprite/HUD logic. It counts shots per key press, with press-and-release debouncing across any number of keycode slots. It also enforces a magazine limit and runs a timed reload, triggered either manually or automatically.

## Interface
Parameters:
- KEY_SLOTS, 2, number of 8-bit keycode slots on the keycode bus
- MAX_SHOTS, 3, shots per magazine (>= 1)
- RELOAD_CYCLES, 50000000, reload duration in Clk cycles (>= 1)
- AUTO_RELOAD, 0, 1 = start reload automatically on empty; 0 = reload only on reload key
- CW, $clog2(MAX_SHOTS+1), derived width of shot counter (localparam)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- keycode  in  8*KEY_SLOTS  pressed-key codes; slot i = keycode[8*i+7:8*i]; 0x00 = no key
- fire_key  in  8  keycode that fires
- reload_key  in  8  keycode that requests reload
- shots_used  out  CW  shots fired from current magazine, 0..MAX_SHOTS
- fire_pulse  out  1  one-cycle strobe per accepted shot, to projectile spawner
- empty  out  1  magazine exhausted (shots_used == MAX_SHOTS)
- reloading  out  1  reload timer running

## Operation
- fire_hit = any slot equals fire_key AND fire_key != 0x00. reload_hit is defined the same way with reload_key. Both are combinational.
- States: READY, HELD, EMPTY, RELOAD. State and all outputs are registered.
- READY:
  - fire_hit -> shots_used += 1, fire_pulse = 1, go to HELD.
  - Otherwise, reload_hit and shots_used > 0 -> go to RELOAD.
  - Fire takes priority over reload.
- HELD:
  - Stays while fire_hit. Reload is ignored.
  - On !fire_hit: shots_used == MAX_SHOTS -> EMPTY; otherwise -> READY.
- EMPTY:
  - empty = 1. Fire is ignored; no fire_pulse.
  - AUTO_RELOAD = 1 -> RELOAD on the next edge.
  - AUTO_RELOAD = 0 -> RELOAD on reload_hit.
- RELOAD:
  - Entry loads the timer with RELOAD_CYCLES-1; reloading = 1.
  - The timer decrements each cycle. Fire and reload keys are ignored.
  - At timer == 0: shots_used <= 0.
  - Exit to HELD if fire_hit, so a held key does not auto-fire. Otherwise exit to READY.
- shots_used never exceeds MAX_SHOTS and never wraps.
- Reload from READY with shots_used == 0 is rejected; the block stays in READY.
- Multiple slots matching the same key count as a single hit.

## Timing
- Reset (sync, any state, including mid-reload) -> next edge:
  - State = READY, shots_used = 0, timer = 0.
  - fire_pulse = 0, empty = 0, reloading = 0.
- Fire latency: fire_hit sampled in READY at edge E. fire_pulse is high and shots_used is incremented in the cycle after E. fire_pulse is high for exactly 1 cycle per press.
- Minimum re-fire spacing: press, release, press is 3 cycles (READY -> HELD -> READY -> HELD).
- empty asserts 1 cycle after the release edge of the MAX_SHOTS-th press.
- RELOAD entry at edge E:
  - reloading is high for exactly RELOAD_CYCLES cycles, E+1 .. E+RELOAD_CYCLES.
  - At edge E+RELOAD_CYCLES: shots_used = 0, empty = 0, reloading = 0.
- With AUTO_RELOAD = 1, RELOAD is entered 1 cycle after empty asserts. empty and reloading overlap only in that transition: empty clears on the RELOAD entry edge.
- Keycode inputs are treated as synchronous to Clk; no internal synchroniser.

## Test plan
Parameters for all scenarios: KEY_SLOTS=2, MAX_SHOTS=3, RELOAD_CYCLES=4, fire_key=0x2C, reload_key=0x15.
- Reset mid-RELOAD with shots_used=3 -> next cycle shots_used=0, reloading=0, empty=0, fire_pulse=0.
- Hold 0x2C in slot 1 for 10 cycles, then release -> exactly one fire_pulse, shots_used=1, state returns to READY.
- Three press/release pairs (0x2C alternating slot 0 and slot 1), AUTO_RELOAD=0 -> 3 fire_pulses and shots_used=3, empty=1. A 4th press gives no pulse.
- From empty=1, present 0x15 -> reloading high for 4 cycles, then shots_used=0, empty=0.
- AUTO_RELOAD=1, 3 shots -> RELOAD starts 1 cycle after empty without any key. Holding 0x2C through reload end -> no fire_pulse until release and re-press.
- keycode=0x2C15 (fire and reload simultaneous) in READY with shots_used=1 -> fire wins, shots_used=2, no reload. Reload key with shots_used=0 -> ignored. fire_key=0x00 with idle keycode=0x0000 -> no shot.

Source files
------------

// File: rtl/venom_ammo_ctrl.sv
// venom_ammo_ctrl: shot/ammo controller for the venom weapon.
// Turns keycode-bus activity into one fire strobe per key press, tracks the
// magazine, and runs a timed reload (manual via reload key, or automatic).
//
// state  | meaning
// -------+-----------------------------------------------------------
// READY  | idle, a fire press is accepted, reload accepted if shots > 0
// HELD   | fire key still down after a shot; waits for release
// EMPTY  | magazine exhausted, fire ignored, waiting to start reload
// RELOAD | reload timer counting down; keys ignored until it expires
module venom_ammo_ctrl #(
   parameter int KEY_SLOTS      = 2,
   parameter int MAX_SHOTS      = 3,
   parameter int RELOAD_CYCLES  = 50000000,
   parameter int AUTO_RELOAD    = 0,
   localparam int CW            = $clog2(MAX_SHOTS + 1)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [8*KEY_SLOTS-1:0] keycode,
   input  logic [7:0]             fire_key,
   input  logic [7:0]             reload_key,
   output logic [CW-1:0]          shots_used,
   output logic                   fire_pulse,
   output logic                   empty,
   output logic                   reloading
);

   // Timer only ever holds RELOAD_CYCLES-1 down to 0.
   localparam int TW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(RELOAD_CYCLES - 1);
   localparam logic [CW-1:0] SHOTS_MAX  = CW'(MAX_SHOTS);

   typedef enum logic [1:0] {
      S_READY  = 2'd0,
      S_HELD   = 2'd1,
      S_EMPTY  = 2'd2,
      S_RELOAD = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [TW-1:0]   timer, timer_n;
   logic [CW-1:0]   shots_n;
   logic            pulse_n;
   logic            fire_match, reload_match;
   logic            fire_hit, reload_hit;

   // Key detection: any slot matching counts once; a zero key never matches
   // so idle slots (0x00) cannot trigger an unassigned action.
   always_comb begin
      fire_match   = 1'b0;
      reload_match = 1'b0;
      for (int i = 0; i < KEY_SLOTS; i++) begin
         if (keycode[8*i +: 8] == fire_key)   fire_match   = 1'b1;
         if (keycode[8*i +: 8] == reload_key) reload_match = 1'b1;
      end
      fire_hit   = fire_match   && (fire_key   != 8'h00);
      reload_hit = reload_match && (reload_key != 8'h00);
   end

   // Next-state, next shot count, next timer and strobe decision.
   always_comb begin
      state_n = state;
      shots_n = shots_used;
      timer_n = timer;
      pulse_n = 1'b0;
      case (state)
         S_READY: begin
            if (fire_hit && (shots_used != SHOTS_MAX)) begin
               shots_n = shots_used + CW'(1);
               pulse_n = 1'b1;
               state_n = S_HELD;
            end else if (reload_hit && (shots_used != '0)) begin
               timer_n = TIMER_LOAD;
               state_n = S_RELOAD;
            end
         end
         S_HELD: begin
            if (!fire_hit) begin
               state_n = (shots_used == SHOTS_MAX) ? S_EMPTY : S_READY;
            end
         end
         S_EMPTY: begin
            if ((AUTO_RELOAD != 0) || reload_hit) begin
               timer_n = TIMER_LOAD;
               state_n = S_RELOAD;
            end
         end
         S_RELOAD: begin
            if (timer == '0) begin
               shots_n = '0;
               // A key still held from before the reload must be released
               // and pressed again before it fires.
               state_n = fire_hit ? S_HELD : S_READY;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         default: state_n = S_READY;
      endcase
   end

   // State and registered outputs; flags follow the state being entered.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= S_READY;
         timer      <= '0;
         shots_used <= '0;
         fire_pulse <= 1'b0;
         empty      <= 1'b0;
         reloading  <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         shots_used <= shots_n;
         fire_pulse <= pulse_n;
         empty      <= (state_n == S_EMPTY);
         reloading  <= (state_n == S_RELOAD);
      end
   end

endmodule

// File: tb/tb_venom_ammo_ctrl.sv
// Directed bench for venom_ammo_ctrl: one manual-reload and one auto-reload
// instance, each held in reset while the other is exercised.
module tb_venom_ammo_ctrl;

   logic        Clk;
   logic        rst_man, rst_auto;
   logic [15:0] keycode;
   logic [7:0]  fire_key, reload_key;
   logic [1:0]  shots_man, shots_auto;
   logic        fp_man, fp_auto, empty_man, empty_auto, rel_man, rel_auto;

   int checks = 0;
   int failures = 0;
   int pulses_man = 0;
   int pulses_auto = 0;

   venom_ammo_ctrl #(.KEY_SLOTS(2), .MAX_SHOTS(3), .RELOAD_CYCLES(4), .AUTO_RELOAD(0)) u_man (
      .Clk(Clk), .Reset(rst_man), .keycode(keycode), .fire_key(fire_key), .reload_key(reload_key),
      .shots_used(shots_man), .fire_pulse(fp_man), .empty(empty_man), .reloading(rel_man));

   venom_ammo_ctrl #(.KEY_SLOTS(2), .MAX_SHOTS(3), .RELOAD_CYCLES(4), .AUTO_RELOAD(1)) u_auto (
      .Clk(Clk), .Reset(rst_auto), .keycode(keycode), .fire_key(fire_key), .reload_key(reload_key),
      .shots_used(shots_auto), .fire_pulse(fp_auto), .empty(empty_auto), .reloading(rel_auto));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n clock edges; outputs are sampled 1 ns after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
         pulses_man  += int'(fp_man);
         pulses_auto += int'(fp_auto);
      end
   endtask

   task automatic fire_once(input int slot);
      keycode = (slot == 0) ? 16'h002C : 16'h2C00;
      step(1);
      keycode = 16'h0000;
      step(1);
   endtask

   initial begin
      rst_man = 1'b1; rst_auto = 1'b1;
      keycode = 16'h0000; fire_key = 8'h2C; reload_key = 8'h15;
      step(2);
      check_val("rst_shots", int'(shots_man), 0);
      check_val("rst_pulse", int'(fp_man), 0);
      check_val("rst_empty", int'(empty_man), 0);
      check_val("rst_reloading", int'(rel_man), 0);
      rst_man = 1'b0;
      step(1);

      // Long hold in slot 1: one shot only
      pulses_man = 0;
      keycode = 16'h2C00; step(1);
      check_val("hold_first_pulse", int'(fp_man), 1);
      check_val("hold_first_shots", int'(shots_man), 1);
      step(9);
      keycode = 16'h0000; step(1);
      check_val("hold_pulse_count", pulses_man, 1);
      check_val("hold_shots", int'(shots_man), 1);
      check_val("hold_empty", int'(empty_man), 0);
      keycode = 16'h002C; step(1);
      check_val("refire_pulse", int'(fp_man), 1);
      check_val("refire_shots", int'(shots_man), 2);
      keycode = 16'h0000; step(1);

      // Three shots alternating slots, then a blocked 4th press
      rst_man = 1'b1; step(1); rst_man = 1'b0;
      pulses_man = 0;
      fire_once(0); fire_once(1);
      check_val("two_shots_not_empty", int'(empty_man), 0);
      fire_once(0);
      check_val("mag_pulses", pulses_man, 3);
      check_val("mag_shots", int'(shots_man), 3);
      check_val("mag_empty", int'(empty_man), 1);
      check_val("mag_not_reloading", int'(rel_man), 0);
      keycode = 16'h2C00; step(1);
      check_val("fourth_no_pulse", int'(fp_man), 0);
      step(2);
      keycode = 16'h0000; step(1);
      check_val("fourth_pulses", pulses_man, 3);
      check_val("fourth_shots", int'(shots_man), 3);
      check_val("fourth_empty", int'(empty_man), 1);

      // Manual reload from empty: 4 cycles of reloading
      keycode = 16'h0015; step(1);
      keycode = 16'h0000;
      check_val("reload_entry_empty", int'(empty_man), 0);
      for (int k = 0; k < 4; k++) begin
         check_val("reload_active", int'(rel_man), 1);
         check_val("reload_shots_held", int'(shots_man), 3);
         step(1);
      end
      check_val("reload_done_flag", int'(rel_man), 0);
      check_val("reload_done_shots", int'(shots_man), 0);
      check_val("reload_done_empty", int'(empty_man), 0);

      // Reset in the middle of a reload
      fire_once(0); fire_once(1); fire_once(0);
      keycode = 16'h1500; step(1);
      keycode = 16'h0000; step(1);
      check_val("midrel_pre_reloading", int'(rel_man), 1);
      rst_man = 1'b1; step(1);
      check_val("midrel_shots", int'(shots_man), 0);
      check_val("midrel_reloading", int'(rel_man), 0);
      check_val("midrel_empty", int'(empty_man), 0);
      check_val("midrel_pulse", int'(fp_man), 0);
      rst_man = 1'b0; step(1);
      check_val("midrel_stays_idle", int'(rel_man), 0);

      // Fire and reload together: fire wins, reload ignored while held
      fire_once(1);
      keycode = 16'h2C15; step(1);
      check_val("simul_pulse", int'(fp_man), 1);
      check_val("simul_shots", int'(shots_man), 2);
      check_val("simul_no_reload", int'(rel_man), 0);
      step(2);
      check_val("simul_held_no_reload", int'(rel_man), 0);
      keycode = 16'h0000; step(1);
      check_val("simul_release_shots", int'(shots_man), 2);

      // Both slots match: single hit
      pulses_man = 0;
      keycode = 16'h2C2C; step(3);
      keycode = 16'h0000; step(1);
      check_val("dual_slot_pulses", pulses_man, 1);
      check_val("dual_slot_shots", int'(shots_man), 3);
      check_val("dual_slot_empty", int'(empty_man), 1);

      // Reload with zero shots is rejected
      rst_man = 1'b1; step(1); rst_man = 1'b0;
      keycode = 16'h1500; step(2);
      check_val("reload_zero_rejected", int'(rel_man), 0);
      keycode = 16'h0000;

      // Unassigned fire key never matches idle slots
      fire_key = 8'h00; pulses_man = 0;
      step(3);
      check_val("nullkey_pulses", pulses_man, 0);
      check_val("nullkey_shots", int'(shots_man), 0);
      fire_key = 8'h2C;

      // Auto reload instance
      rst_man = 1'b1; rst_auto = 1'b0;
      pulses_auto = 0;
      fire_once(0); fire_once(1); fire_once(0);
      check_val("auto_empty", int'(empty_auto), 1);
      check_val("auto_not_yet_reloading", int'(rel_auto), 0);
      check_val("auto_shots", int'(shots_auto), 3);
      step(1);
      check_val("auto_reload_started", int'(rel_auto), 1);
      check_val("auto_empty_cleared", int'(empty_auto), 0);
      keycode = 16'h002C;
      step(3);
      check_val("auto_reload_last", int'(rel_auto), 1);
      step(1);
      check_val("auto_reload_end", int'(rel_auto), 0);
      check_val("auto_reload_shots", int'(shots_auto), 0);
      check_val("auto_held_no_pulse", int'(fp_auto), 0);
      step(2);
      check_val("auto_held_pulses", pulses_auto, 3);
      keycode = 16'h0000; step(1);
      keycode = 16'h2C00; step(1);
      check_val("auto_repress_pulse", int'(fp_auto), 1);
      check_val("auto_repress_shots", int'(shots_auto), 1);
      check_val("auto_total_pulses", pulses_auto, 4);
      keycode = 16'h0000; step(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
